// File: rtl/lomo_frame_pkg.sv
// Shared constants, FSM state type and helpers for the LOMO frame receiver.
package lomo_frame_pkg;

    localparam int WORDS_PER_FRAME = 20;
    localparam int BITS_PER_WORD   = 16;
    localparam int MARK_HI_IDX     = 0;
    localparam int MARK_LO_IDX     = 10;
    localparam int AUX_BYTES       = 7;
    localparam int AUX_HI_FIRST    = 1;   // words 1..7 carry the aux high nibbles
    localparam int AUX_LO_FIRST    = 11;  // words 11..17 carry the aux low nibbles

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    // Words whose low nibble must be zero in a well-formed frame.
    function automatic logic is_pad_word(input logic [4:0] idx);
        return (idx == 5'd8) || (idx == 5'd9) || (idx == 5'd18) || (idx == 5'd19);
    endfunction

endpackage

// File: rtl/lomo_frame_rx_if.sv
// Output bus of the LOMO frame receiver: word stream, frame summary and error strobes.
interface lomo_frame_rx_if;
    import lomo_frame_pkg::*;

    logic [BITS_PER_WORD-1:0] word_data;
    logic [4:0]               word_idx;
    logic                     word_valid;
    logic                     frame_done;
    logic [8:0]               frm_num;
    logic [5:0]               str_num;
    logic [8*AUX_BYTES-1:0]   aux;
    logic                     err_fmt;
    logic                     err_seq;
    logic                     err_trunc;

    modport master (output word_data, word_idx, word_valid, frame_done, frm_num,
                           str_num, aux, err_fmt, err_seq, err_trunc);
    modport slave  (input  word_data, word_idx, word_valid, frame_done, frm_num,
                           str_num, aux, err_fmt, err_seq, err_trunc);

endinterface

// File: rtl/lomo_edge_sync.sv
// Three-flop synchronizer for an asynchronous link line, with rising-edge detect.
module lomo_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [2:0] s_q, s_d;

    always_comb s_d = {s_q[1:0], d};

    always_ff @(posedge clk) begin
        if (reset) s_q <= '0;
        else       s_q <= s_d;
    end

    assign level = s_q[1];
    assign rise  = s_q[1] & ~s_q[2];

endmodule

// File: rtl/lomo_frame_rx.sv
// LOMO MK/CLK/DAT frame receiver: deserializes 20x16-bit words, checks format and
// frame-number continuity, and reassembles the seven split aux bytes.
module lomo_frame_rx
    import lomo_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MK,
    input  logic            CLK,
    input  logic            DAT,
    lomo_frame_rx_if.master bus
);

    localparam int            TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic mk_rise, clk_rise, dat_lvl;
    logic mk_lvl_unused, clk_lvl_unused, dat_rise_unused;

    lomo_edge_sync u_mk  (.clk(clk), .reset(reset), .d(MK),  .level(mk_lvl_unused),  .rise(mk_rise));
    lomo_edge_sync u_clk (.clk(clk), .reset(reset), .d(CLK), .level(clk_lvl_unused), .rise(clk_rise));
    lomo_edge_sync u_dat (.clk(clk), .reset(reset), .d(DAT), .level(dat_lvl),        .rise(dat_rise_unused));

    state_t                         state_q, state_d;
    logic [3:0]                     bit_cnt_q, bit_cnt_d;
    logic [4:0]                     word_cnt_q, word_cnt_d;
    logic [BITS_PER_WORD-2:0]       sh_q, sh_d;
    logic [TW-1:0]                  tmo_q, tmo_d;
    logic [BITS_PER_WORD-2:0]       w0_q, w0_d;  // word 0 minus its marker bit
    logic [AUX_BYTES-1:0][3:0]      hold_q, hold_d;
    logic [AUX_BYTES-1:0][7:0]      aux_acc_q, aux_acc_d, aux_q, aux_d;
    logic                           fmt_bad_q, fmt_bad_d, have_prev_q, have_prev_d;
    logic [8:0]                     prev_frm_q, prev_frm_d, frm_num_q, frm_num_d;
    logic [5:0]                     str_num_q, str_num_d;
    logic [BITS_PER_WORD-1:0]       word_data_q, word_data_d;
    logic [4:0]                     word_idx_q, word_idx_d;
    logic                           word_valid_q, word_valid_d, frame_done_q, frame_done_d;
    logic                           err_fmt_q, err_fmt_d, err_seq_q, err_seq_d;
    logic                           err_trunc_q, err_trunc_d;

    logic [BITS_PER_WORD-1:0] word;
    logic [8:0]               done_frm;
    logic                     start, take;

    assign word     = {sh_q, dat_lvl};
    assign done_frm = w0_q[14:6];

    // NOTE: every variable assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        sh_d         = sh_q;
        tmo_d        = tmo_q;
        w0_d         = w0_q;
        hold_d       = hold_q;
        aux_acc_d    = aux_acc_q;
        aux_d        = aux_q;
        fmt_bad_d    = fmt_bad_q;
        have_prev_d  = have_prev_q;
        prev_frm_d   = prev_frm_q;
        frm_num_d    = frm_num_q;
        str_num_d    = str_num_q;
        word_data_d  = word_data_q;
        word_idx_d   = word_idx_q;
        word_valid_d = 1'b0;
        frame_done_d = 1'b0;
        err_fmt_d    = 1'b0;
        err_seq_d    = 1'b0;
        err_trunc_d  = 1'b0;
        start        = 1'b0;
        take         = 1'b0;

        unique case (state_q)
            IDLE: start = mk_rise;
            RECV: begin
                if (mk_rise) begin
                    start       = 1'b1;
                    err_trunc_d = 1'b1;
                end else if (clk_rise) begin
                    take = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    err_trunc_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                err_fmt_d    = fmt_bad_q;
                err_seq_d    = have_prev_q && (done_frm != prev_frm_q + 9'd1);
                frm_num_d    = done_frm;
                str_num_d    = w0_q[5:0];
                aux_d        = aux_acc_q;
                if (!fmt_bad_q) begin
                    have_prev_d = 1'b1;
                    prev_frm_d  = done_frm;
                end
                state_d = IDLE;
                start   = mk_rise;
            end
            default: state_d = IDLE;
        endcase

        // A CLK edge coincident with the frame start is the first (MSB) bit of word 0.
        if (start) begin
            state_d    = RECV;
            bit_cnt_d  = 4'd0;
            word_cnt_d = 5'd0;
            tmo_d      = '0;
            fmt_bad_d  = 1'b0;
            if (clk_rise) begin
                sh_d      = {sh_q[BITS_PER_WORD-3:0], dat_lvl};
                bit_cnt_d = 4'd1;
            end
        end

        if (take) begin
            tmo_d     = '0;
            sh_d      = {sh_q[BITS_PER_WORD-3:0], dat_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(BITS_PER_WORD - 1)) begin
                word_data_d  = word;
                word_idx_d   = word_cnt_q;
                word_valid_d = 1'b1;
                word_cnt_d   = word_cnt_q + 5'd1;
                if (word_cnt_q == 5'(MARK_HI_IDX)) begin
                    w0_d      = word[15:1];
                    fmt_bad_d = ~word[0];
                end
                if (word_cnt_q == 5'(MARK_LO_IDX))
                    fmt_bad_d = fmt_bad_q | word[0] | (word[15:1] != w0_q);
                if (is_pad_word(word_cnt_q))
                    fmt_bad_d = fmt_bad_q | (|word[3:0]);
                for (int k = 0; k < AUX_BYTES; k++) begin
                    if (word_cnt_q == 5'(AUX_HI_FIRST + k)) hold_d[k] = word[3:0];
                    if (word_cnt_q == 5'(AUX_LO_FIRST + k)) aux_acc_d[k] = {hold_q[k], word[3:0]};
                end
                if (word_cnt_q == 5'(WORDS_PER_FRAME - 1)) state_d = DONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: holding/accumulator registers are reset as well, so no stale aux nibble survives a reset.
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            sh_q         <= '0;
            tmo_q        <= '0;
            w0_q         <= '0;
            hold_q       <= '0;
            aux_acc_q    <= '0;
            aux_q        <= '0;
            fmt_bad_q    <= 1'b0;
            have_prev_q  <= 1'b0;
            prev_frm_q   <= '0;
            frm_num_q    <= '0;
            str_num_q    <= '0;
            word_data_q  <= '0;
            word_idx_q   <= '0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_fmt_q    <= 1'b0;
            err_seq_q    <= 1'b0;
            err_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            sh_q         <= sh_d;
            tmo_q        <= tmo_d;
            w0_q         <= w0_d;
            hold_q       <= hold_d;
            aux_acc_q    <= aux_acc_d;
            aux_q        <= aux_d;
            fmt_bad_q    <= fmt_bad_d;
            have_prev_q  <= have_prev_d;
            prev_frm_q   <= prev_frm_d;
            frm_num_q    <= frm_num_d;
            str_num_q    <= str_num_d;
            word_data_q  <= word_data_d;
            word_idx_q   <= word_idx_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            err_fmt_q    <= err_fmt_d;
            err_seq_q    <= err_seq_d;
            err_trunc_q  <= err_trunc_d;
        end
    end

    assign bus.word_data  = word_data_q;
    assign bus.word_idx   = word_idx_q;
    assign bus.word_valid = word_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frm_num    = frm_num_q;
    assign bus.str_num    = str_num_q;
    assign bus.aux        = aux_q;
    assign bus.err_fmt    = err_fmt_q;
    assign bus.err_seq    = err_seq_q;
    assign bus.err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_lomo_frame_rx.sv
// Self-checking bench for lomo_frame_rx: directed vector table, corner-case sequences
// and randomized frames against a word-array reference model.
module tb_lomo_frame_rx;
    import lomo_frame_pkg::*;

    localparam int TMO  = 4096;
    localparam int HALF = 2;  // link CLK half period in clk cycles
    localparam int NBIT = WORDS_PER_FRAME * BITS_PER_WORD;

    typedef logic [15:0] frame_t [WORDS_PER_FRAME];
    typedef struct {
        logic [8:0]  frm;
        logic [5:0]  str;
        logic [55:0] aux;
        logic        fmt;
        logic        seq;
        logic        timing_ok;
    } frame_rec_t;
    typedef struct {
        logic [8:0]  frm;
        logic [5:0]  str;
        logic [55:0] aux;
        int          corrupt;
        logic        exp_fmt;
        logic        exp_seq;
    } vec_t;

    logic clk = 1'b0;
    logic reset, mk, lclk, dat;

    int n_checks = 0;
    int n_errors = 0;
    frame_rec_t  got_frames[$];
    logic [20:0] got_words[$];
    int   trunc_cnt = 0;
    int   stray_cnt = 0;
    logic last_wv19 = 1'b0;
    int   ref_prev  = -1;

    frame_t     w, wb;
    frame_rec_t e, eb;
    vec_t       vecs[11];
    logic [8:0]  rf;
    logic [5:0]  rs;
    logic [55:0] ra;
    int          rc;

    lomo_frame_rx_if bus ();

    lomo_frame_rx #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .MK(mk), .CLK(lclk), .DAT(dat), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.word_valid) got_words.push_back({bus.word_idx, bus.word_data});
        if (bus.frame_done)
            got_frames.push_back('{frm: bus.frm_num, str: bus.str_num, aux: bus.aux,
                                   fmt: bus.err_fmt, seq: bus.err_seq, timing_ok: last_wv19});
        else if (bus.err_fmt || bus.err_seq) stray_cnt++;
        if (bus.err_trunc) trunc_cnt++;
        last_wv19 = bus.word_valid && (bus.word_idx == 5'd19);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_frames.delete();
        got_words.delete();
        trunc_cnt = 0;
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic link_bit(input logic b);
        dat = b;
        repeat (HALF) @(negedge clk);
        lclk = 1'b1;
        repeat (HALF) @(negedge clk);
        lclk = 1'b0;
    endtask

    task automatic mk_pulse();
        mk = 1'b1;
        repeat (HALF) @(negedge clk);
        mk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input frame_t fw, input int first, input int last);
        for (int i = first; i < last; i++) link_bit(fw[i / 16][15 - (i % 16)]);
    endtask

    task automatic build_frame(input logic [8:0] frm, input logic [5:0] str, input logic [55:0] aux,
                               input int corrupt, output frame_t fw);
        for (int i = 0; i < WORDS_PER_FRAME; i++) fw[i] = {12'($urandom), 4'h0};
        fw[0]  = {frm, str, 1'b1};
        fw[10] = {frm, str, 1'b0};
        for (int k = 0; k < AUX_BYTES; k++) begin
            fw[k + 1][3:0]  = aux[8*k + 4 +: 4];
            fw[k + 11][3:0] = aux[8*k +: 4];
        end
        case (corrupt)
            1: fw[10][0] = 1'b1;
            2: fw[18][3:0] = 4'h9;
            3: fw[10][9] = ~fw[10][9];
            4: fw[0][0] = 1'b0;
            5: fw[8][3:0] = 4'h1;
            default: ;
        endcase
    endtask

    // Reference: decode the whole frame from its word array; continuity tracked as an int.
    task automatic model(input frame_t fw, output frame_rec_t r);
        r.frm = fw[0][15:7];
        r.str = fw[0][6:1];
        for (int k = 0; k < AUX_BYTES; k++) r.aux[8*k +: 8] = {fw[k + 1][3:0], fw[k + 11][3:0]};
        r.fmt = (fw[0][0] != 1'b1) || (fw[10][0] != 1'b0) || (fw[10][15:1] != fw[0][15:1])
             || (fw[8][3:0] != 4'h0) || (fw[9][3:0] != 4'h0)
             || (fw[18][3:0] != 4'h0) || (fw[19][3:0] != 4'h0);
        r.seq = (ref_prev >= 0) && (int'(r.frm) != (ref_prev + 1) % 512);
        if (!r.fmt) ref_prev = int'(r.frm);
        r.timing_ok = 1'b1;
    endtask

    task automatic check_rec(input string tag, input frame_rec_t g, input frame_rec_t x);
        check({tag, " frm_num"}, 64'(g.frm), 64'(x.frm));
        check({tag, " str_num"}, 64'(g.str), 64'(x.str));
        check({tag, " aux"}, 64'(g.aux), 64'(x.aux));
        check({tag, " err_fmt"}, 64'(g.fmt), 64'(x.fmt));
        check({tag, " err_seq"}, 64'(g.seq), 64'(x.seq));
        check({tag, " done_timing"}, 64'(g.timing_ok), 64'd1);
    endtask

    task automatic check_frame(input string tag, input frame_t fw, input frame_rec_t x);
        check({tag, " frames"}, 64'(got_frames.size()), 64'd1);
        check({tag, " words"}, 64'(got_words.size()), 64'd20);
        for (int i = 0; i < got_words.size() && i < WORDS_PER_FRAME; i++)
            check({tag, " word"}, 64'(got_words[i]), 64'({5'(i), fw[i]}));
        if (got_frames.size() > 0) check_rec(tag, got_frames[0], x);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " word_data"}, 64'(bus.word_data), 64'd0);
        check({tag, " word_idx"}, 64'(bus.word_idx), 64'd0);
        check({tag, " word_valid"}, 64'(bus.word_valid), 64'd0);
        check({tag, " frame_done"}, 64'(bus.frame_done), 64'd0);
        check({tag, " frm_num"}, 64'(bus.frm_num), 64'd0);
        check({tag, " str_num"}, 64'(bus.str_num), 64'd0);
        check({tag, " aux"}, 64'(bus.aux), 64'd0);
        check({tag, " err_fmt"}, 64'(bus.err_fmt), 64'd0);
        check({tag, " err_seq"}, 64'(bus.err_seq), 64'd0);
        check({tag, " err_trunc"}, 64'(bus.err_trunc), 64'd0);
    endtask

    task automatic run_frame(input frame_t fw);
        clear_mon();
        mk_pulse();
        send_bits(fw, 0, NBIT);
        settle();
    endtask

    initial begin
        vecs[0]  = '{9'd6,   6'd10, 56'h0123456789ABCD, 0, 1'b0, 1'b0};
        vecs[1]  = '{9'd511, 6'd63, 56'hFEDCBA98765432, 0, 1'b0, 1'b1};
        vecs[2]  = '{9'd0,   6'd0,  56'h00000000000000, 0, 1'b0, 1'b0};
        vecs[3]  = '{9'd2,   6'd1,  56'h5A5A5A5A5A5A5A, 0, 1'b0, 1'b1};
        vecs[4]  = '{9'd3,   6'd2,  56'h11223344556677, 1, 1'b1, 1'b0};
        vecs[5]  = '{9'd3,   6'd2,  56'h8899AABBCCDDEE, 0, 1'b0, 1'b0};
        vecs[6]  = '{9'd4,   6'd5,  56'h0F0F0F0F0F0F0F, 2, 1'b1, 1'b0};
        vecs[7]  = '{9'd6,   6'd7,  56'hF0F0F0F0F0F0F0, 3, 1'b1, 1'b1};
        vecs[8]  = '{9'd4,   6'd9,  56'h13579BDF2468AC, 4, 1'b1, 1'b0};
        vecs[9]  = '{9'd4,   6'd9,  56'hC0FFEE00BADA55, 5, 1'b1, 1'b0};
        vecs[10] = '{9'd4,   6'd9,  56'h0A0B0C0D0E0F01, 0, 1'b0, 1'b0};

        mk = 1'b0; lclk = 1'b0; dat = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic good frame: frm 5, str 3, aux byte 0 = 0x65.
        build_frame(9'd5, 6'd3, 56'h65, 0, w);
        w[1]  = 16'h44D6;
        w[11] = 16'h44D5;
        model(w, e);
        run_frame(w);
        check_frame("basic", w, '{frm: 9'd5, str: 6'd3, aux: 56'h65, fmt: 1'b0, seq: 1'b0, timing_ok: 1'b1});

        for (int v = 0; v < 11; v++) begin
            build_frame(vecs[v].frm, vecs[v].str, vecs[v].aux, vecs[v].corrupt, w);
            model(w, e);
            run_frame(w);
            check_frame($sformatf("vec%0d", v), w,
                        '{frm: vecs[v].frm, str: vecs[v].str, aux: vecs[v].aux,
                          fmt: vecs[v].exp_fmt, seq: vecs[v].exp_seq, timing_ok: 1'b1});
        end

        // MK re-rise after word 7 aborts; the next frame decodes from word 0.
        build_frame(9'd5, 6'd1, 56'h31415926535897, 0, w);
        clear_mon();
        mk_pulse();
        send_bits(w, 0, 8 * 16);
        settle();
        check("trunc partial words", 64'(got_words.size()), 64'd8);
        check("trunc before abort", 64'(trunc_cnt), 64'd0);
        model(w, e);
        run_frame(w);
        check("trunc pulse", 64'(trunc_cnt), 64'd1);
        check_frame("after_trunc", w, e);

        // MK and CLK edges coincide: restart wins, that edge is bit 15 of word 0.
        build_frame(9'd6, 6'd2, 56'h27182818284590, 0, w);
        clear_mon();
        mk_pulse();
        send_bits(w, 0, 40);
        clear_mon();
        dat = w[0][15];
        repeat (HALF) @(negedge clk);
        mk = 1'b1; lclk = 1'b1;
        repeat (HALF) @(negedge clk);
        mk = 1'b0; lclk = 1'b0;
        send_bits(w, 1, NBIT);
        settle();
        model(w, e);
        check("coincident trunc", 64'(trunc_cnt), 64'd1);
        check_frame("coincident", w, e);

        // MK rise while in DONE: frame completes, next frame follows with no abort.
        build_frame(9'd7, 6'd4, 56'h00112233445566, 0, w);
        build_frame(9'd8, 6'd4, 56'h778899AABBCCDD, 0, wb);
        clear_mon();
        mk_pulse();
        send_bits(w, 0, NBIT - 1);
        dat = w[19][0];
        repeat (HALF) @(negedge clk);
        lclk = 1'b1;
        @(negedge clk);
        mk = 1'b1;
        @(negedge clk);
        lclk = 1'b0;
        repeat (HALF) @(negedge clk);
        mk = 1'b0;
        send_bits(wb, 0, NBIT);
        settle();
        model(w, e);
        model(wb, eb);
        check("done_mk frames", 64'(got_frames.size()), 64'd2);
        check("done_mk words", 64'(got_words.size()), 64'd40);
        check("done_mk trunc", 64'(trunc_cnt), 64'd0);
        if (got_frames.size() > 1) begin
            check_rec("done_mk first", got_frames[0], e);
            check_rec("done_mk second", got_frames[1], eb);
        end

        // CLK stalls mid word 3: abort after the timeout, then bare CLK edges are ignored.
        build_frame(9'd9, 6'd0, 56'h0, 0, w);
        clear_mon();
        mk_pulse();
        send_bits(w, 0, 3 * 16 + 8);
        clear_mon();
        repeat (4000) @(negedge clk);
        check("timeout early", 64'(trunc_cnt), 64'd0);
        repeat (300) @(negedge clk);
        check("timeout pulse", 64'(trunc_cnt), 64'd1);
        clear_mon();
        send_bits(w, 0, 40);
        settle();
        check("idle clk words", 64'(got_words.size()), 64'd0);
        check("idle clk frames", 64'(got_frames.size()), 64'd0);

        // Reset mid word 12, then a clean frame with no continuity history.
        build_frame(9'd300, 6'd33, 56'hAB, 0, w);
        clear_mon();
        mk_pulse();
        send_bits(w, 0, 12 * 16 + 8);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        ref_prev = -1;
        build_frame(9'd100, 6'd12, 56'h42424242424242, 0, w);
        model(w, e);
        run_frame(w);
        check("post_reset err_seq", 64'(got_frames.size() > 0 ? got_frames[0].seq : 1'b1), 64'd0);
        check_frame("post_reset", w, e);

        for (int n = 0; n < 10; n++) begin
            rf = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'((ref_prev + 1) % 512);
            rs = 6'($urandom);
            ra = {24'($urandom), 32'($urandom)};
            rc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            build_frame(rf, rs, ra, rc, w);
            model(w, e);
            run_frame(w);
            check_frame($sformatf("rand%0d", n), w, e);
        end

        check("stray error strobes", 64'(stray_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
